// File: rtl/jtcop_vram_arb.sv
// Shares one SDRAM read slot between the three BAC06 VRAM readers b0/b1/b2, caching the last word per reader.
// Define JTCOP_VRAM_PRIO_EN for fixed priority b0 > b1 > b2; the default build is round-robin.
module jtcop_vram_arb #(
  parameter logic [13:0] B0_BASE = 14'h0000,
  parameter logic [13:0] B1_BASE = 14'h2000,
  parameter logic [13:0] B2_BASE = 14'h2800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        b0_cs,
  input  logic [12:0] b0_addr,
  output logic [15:0] b0_data,
  output logic        b0_ok,
  input  logic        b1_cs,
  input  logic [10:0] b1_addr,
  output logic [15:0] b1_data,
  output logic        b1_ok,
  input  logic        b2_cs,
  input  logic [10:0] b2_addr,
  output logic [15:0] b2_data,
  output logic        b2_ok,
  output logic        sd_cs,
  output logic [13:0] sd_addr,
  input  logic [15:0] sd_data,
  input  logic        sd_ok
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d, last_q, last_d;
  logic [12:0] req_addr_q, req_addr_d;
  logic [12:0] tag0_q, tag0_d;
  logic [10:0] tag1_q, tag1_d, tag2_q, tag2_d;
  logic [2:0]  val_q, val_d;
  logic [15:0] dat0_q, dat0_d, dat1_q, dat1_d, dat2_q, dat2_d;
  logic        sd_cs_q, sd_cs_d;
  logic [13:0] sd_addr_q, sd_addr_d;

  logic [2:0]  hit, pend;
  logic        busy;
  logic [1:0]  pick;
  logic [13:0] map0, map1, map2;

  assign hit[0] = val_q[0] & (b0_addr == tag0_q);
  assign hit[1] = val_q[1] & (b1_addr == tag1_q);
  assign hit[2] = val_q[2] & (b2_addr == tag2_q);
  assign busy   = (state_q != IDLE);

  assign pend[0] = b0_cs & ~hit[0] & ~(busy & (grant_q == 2'd0));
  assign pend[1] = b1_cs & ~hit[1] & ~(busy & (grant_q == 2'd1));
  assign pend[2] = b2_cs & ~hit[2] & ~(busy & (grant_q == 2'd2));

  assign b0_ok   = b0_cs & hit[0];
  assign b1_ok   = b1_cs & hit[1];
  assign b2_ok   = b2_cs & hit[2];
  assign b0_data = dat0_q;
  assign b1_data = dat1_q;
  assign b2_data = dat2_q;
  assign sd_cs   = sd_cs_q;
  assign sd_addr = sd_addr_q;

  // Region mapping into the shared VRAM word space; overflow wraps silently
  assign map0 = B0_BASE + {1'b0, b0_addr};
  assign map1 = B1_BASE + {3'b0, b1_addr};
  assign map2 = B2_BASE + {3'b0, b2_addr};

  always_comb begin
    pick = 2'd0;
`ifdef JTCOP_VRAM_PRIO_EN
    if (pend[0])      pick = 2'd0;
    else if (pend[1]) pick = 2'd1;
    else              pick = 2'd2;
`else
    case (last_q)
      2'd0:    pick = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
      2'd1:    pick = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
      default: pick = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
    endcase
`endif
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    req_addr_d = req_addr_q;
    tag0_d     = tag0_q;
    tag1_d     = tag1_q;
    tag2_d     = tag2_q;
    val_d      = val_q;
    dat0_d     = dat0_q;
    dat1_d     = dat1_q;
    dat2_d     = dat2_q;
    sd_cs_d    = sd_cs_q;
    sd_addr_d  = sd_addr_q;
    case (state_q)
      IDLE: begin
        sd_cs_d = 1'b0;
        if (|pend) begin
          grant_d = pick;
          sd_cs_d = 1'b1;
          state_d = ISSUE;
          case (pick)
            2'd0:    begin req_addr_d = b0_addr;         sd_addr_d = map0; end
            2'd1:    begin req_addr_d = {2'b0, b1_addr}; sd_addr_d = map1; end
            default: begin req_addr_d = {2'b0, b2_addr}; sd_addr_d = map2; end
          endcase
        end
      end
      // sd_ok may still be high from the previous slot user, so it is not trusted here
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sd_ok) begin
          case (grant_q)
            2'd0:    begin dat0_d = sd_data; tag0_d = req_addr_q;        val_d[0] = 1'b1; end
            2'd1:    begin dat1_d = sd_data; tag1_d = req_addr_q[10:0];  val_d[1] = 1'b1; end
            default: begin dat2_d = sd_data; tag2_d = req_addr_q[10:0];  val_d[2] = 1'b1; end
          endcase
          last_d  = grant_q;
          sd_cs_d = 1'b0;
          state_d = GAP;
        end
      end
      default: begin
        sd_cs_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 2'd0;
      last_q     <= 2'd2;
      req_addr_q <= '0;
      tag0_q     <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      val_q      <= '0;
      dat0_q     <= '0;
      dat1_q     <= '0;
      dat2_q     <= '0;
      sd_cs_q    <= 1'b0;
      sd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      req_addr_q <= req_addr_d;
      tag0_q     <= tag0_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      val_q      <= val_d;
      dat0_q     <= dat0_d;
      dat1_q     <= dat1_d;
      dat2_q     <= dat2_d;
      sd_cs_q    <= sd_cs_d;
      sd_addr_q  <= sd_addr_d;
    end
  end
endmodule

// File: tb/tb_jtcop_vram_arb.sv
// Bench for jtcop_vram_arb: directed scenarios plus random traffic against a per-reader cache model.
module tb_jtcop_vram_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        b0_cs, b1_cs, b2_cs, sd_ok;
  logic [12:0] b0_addr;
  logic [10:0] b1_addr, b2_addr;
  logic [15:0] b0_data, b1_data, b2_data, sd_data;
  logic        b0_ok, b1_ok, b2_ok, sd_cs;
  logic [13:0] sd_addr;

  jtcop_vram_arb dut (
    .clk(clk), .rst(rst),
    .b0_cs(b0_cs), .b0_addr(b0_addr), .b0_data(b0_data), .b0_ok(b0_ok),
    .b1_cs(b1_cs), .b1_addr(b1_addr), .b1_data(b1_data), .b1_ok(b1_ok),
    .b2_cs(b2_cs), .b2_addr(b2_addr), .b2_data(b2_data), .b2_ok(b2_ok),
    .sd_cs(sd_cs), .sd_addr(sd_addr), .sd_data(sd_data), .sd_ok(sd_ok)
  );

  // Second instance only for the base-address wrap case
  logic        w_b0_cs = 1'b0, w_b1_cs = 1'b0, w_b2_cs = 1'b1, w_sd_ok = 1'b0;
  logic [12:0] w_b0_addr = '0;
  logic [10:0] w_b1_addr = '0, w_b2_addr = 11'h002;
  logic [15:0] w_sd_data = '0;
  logic [15:0] w_b0_data, w_b1_data, w_b2_data;
  logic        w_b0_ok, w_b1_ok, w_b2_ok, w_sd_cs;
  logic [13:0] w_sd_addr;

  jtcop_vram_arb #(.B2_BASE(14'h3FFF)) dut_w (
    .clk(clk), .rst(rst),
    .b0_cs(w_b0_cs), .b0_addr(w_b0_addr), .b0_data(w_b0_data), .b0_ok(w_b0_ok),
    .b1_cs(w_b1_cs), .b1_addr(w_b1_addr), .b1_data(w_b1_data), .b1_ok(w_b1_ok),
    .b2_cs(w_b2_cs), .b2_addr(w_b2_addr), .b2_data(w_b2_data), .b2_ok(w_b2_ok),
    .sd_cs(w_sd_cs), .sd_addr(w_sd_addr), .sd_data(w_sd_data), .sd_ok(w_sd_ok)
  );

  int n_assert = 0, n_fail = 0;

  // Reference model: what each reader has cached, plus the slot transaction in flight
  logic [12:0] m_tag [3];
  logic        m_val [3];
  logic [15:0] m_dat [3];
  int          m_last;
  bit          busy;
  int          cur_g, tcnt;
  logic [12:0] cur_req;
  logic [13:0] cur_sd;
  logic        prev_cs1, prev_cs2;
  int          sd_cnt, lat;
  bit          stale;
  int          glog_g [$];
  logic [13:0] glog_a [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [13:0] a);
    if (a == 14'h2005) return 16'hBEEF;
    return {~a[7:0], a[13:6]} ^ 16'h1234;
  endfunction

  function automatic logic [13:0] map(input int g, input logic [12:0] a);
    case (g)
      0:       return 14'h0000 + {1'b0, a};
      1:       return 14'h2000 + {3'b0, a[10:0]};
      default: return 14'h2800 + {3'b0, a[10:0]};
    endcase
  endfunction

  function automatic int pick(input logic [2:0] p, input int last);
`ifdef JTCOP_VRAM_PRIO_EN
    for (int k = 0; k < 3; k++) if (p[k]) return k;
`else
    for (int k = 1; k <= 3; k++) if (p[(last + k) % 3]) return (last + k) % 3;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_tag[i] = '0; m_val[i] = 1'b0; m_dat[i] = '0;
    end
    m_last = 2; busy = 1'b0; cur_g = 0; tcnt = 0;
    prev_cs1 = 1'b0; prev_cs2 = 1'b0; sd_cnt = 0;
    sd_ok = 1'b0; sd_data = '0;
  endtask

  // One clock: check what the DUT did at the posedge against the model, then drive the SDRAM side
  task automatic cycle();
    logic        cs_s [3];
    logic [12:0] ad_s [3];
    logic [2:0]  pend;
    logic        ok_edge, fall;
    int          g;
    cs_s[0] = b0_cs; cs_s[1] = b1_cs; cs_s[2] = b2_cs;
    ad_s[0] = b0_addr; ad_s[1] = {2'b0, b1_addr}; ad_s[2] = {2'b0, b2_addr};
    ok_edge = sd_ok;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      pend[i] = cs_s[i] && !(m_val[i] && ad_s[i] == m_tag[i]) && !(busy && cur_g == i);
    if (!prev_cs1 && !prev_cs2) begin
      chk("idle_request", {31'b0, sd_cs}, {31'b0, pend != 3'b0});
      if (pend != 3'b0 && sd_cs) begin
        g = pick(pend, m_last);
        chk("grant_addr", {18'b0, sd_addr}, {18'b0, map(g, ad_s[g])});
        busy = 1'b1; cur_g = g; cur_req = ad_s[g]; cur_sd = map(g, ad_s[g]); tcnt = 0;
        glog_g.push_back(g); glog_a.push_back(sd_addr);
      end
    end else if (prev_cs1) begin
      tcnt++;
      fall = (tcnt >= 2) && ok_edge;
      chk("sd_cs_hold", {31'b0, sd_cs}, {31'b0, !fall});
      if (!fall) chk("sd_addr_stable", {18'b0, sd_addr}, {18'b0, cur_sd});
      else begin
        m_tag[cur_g] = cur_req; m_val[cur_g] = 1'b1; m_dat[cur_g] = mem(cur_sd);
        m_last = cur_g; busy = 1'b0;
      end
    end else begin
      chk("gap_low", {31'b0, sd_cs}, 32'd0);
    end
    chk("b0_ok", {31'b0, b0_ok}, {31'b0, cs_s[0] && m_val[0] && ad_s[0] == m_tag[0]});
    chk("b1_ok", {31'b0, b1_ok}, {31'b0, cs_s[1] && m_val[1] && ad_s[1] == m_tag[1]});
    chk("b2_ok", {31'b0, b2_ok}, {31'b0, cs_s[2] && m_val[2] && ad_s[2] == m_tag[2]});
    chk("b0_data", {16'b0, b0_data}, {16'b0, m_dat[0]});
    chk("b1_data", {16'b0, b1_data}, {16'b0, m_dat[1]});
    chk("b2_data", {16'b0, b2_data}, {16'b0, m_dat[2]});
    prev_cs2 = prev_cs1; prev_cs1 = sd_cs;
    if (sd_cs) sd_cnt++; else sd_cnt = 0;
    if (stale && sd_cnt <= 1) begin
      sd_ok = 1'b1; sd_data = 16'hDEAD;
    end else if (sd_cs && sd_cnt >= lat) begin
      sd_ok = 1'b1; sd_data = mem(sd_addr);
    end else begin
      sd_ok = 1'b0; sd_data = 16'h0000;
    end
  endtask

  initial begin
    int s;
    rst = 1'b1; stale = 1'b0; lat = 2;
    b0_cs = 1'b0; b1_cs = 1'b0; b2_cs = 1'b0;
    b0_addr = '0; b1_addr = '0; b2_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sd_cs", {31'b0, sd_cs}, 32'd0);
    chk("rst_sd_addr", {18'b0, sd_addr}, 32'd0);
    chk("rst_ok", {29'b0, b0_ok, b1_ok, b2_ok}, 32'd0);
    chk("rst_data", {b0_data, b1_data ^ b2_data}, 32'd0);
    rst = 1'b0;

    // All three readers at once, fresh after reset
    b0_cs = 1'b1; b1_cs = 1'b1; b2_cs = 1'b1;
    b0_addr = 13'h0100; b1_addr = 11'h100; b2_addr = 11'h100; lat = 1;
    s = glog_g.size();
    repeat (20) cycle();
    chk("rr_count", glog_g.size(), s + 3);
    if (glog_g.size() >= s + 3) begin
      chk("rr_first", glog_g[s], 0);
      chk("rr_second", glog_g[s+1], 1);
      chk("rr_third", glog_g[s+2], 2);
    end
    b0_cs = 1'b0; b1_cs = 1'b0; b2_cs = 1'b0;
    repeat (3) cycle();

    // Single read, then a held hit
    b1_cs = 1'b1; b1_addr = 11'h005; lat = 2;
    s = glog_a.size();
    repeat (10) cycle();
    chk("single_count", glog_a.size(), s + 1);
    if (glog_a.size() > s) chk("single_sd_addr", {18'b0, glog_a[s]}, 32'h2005);
    chk("single_ok", {31'b0, b1_ok}, 32'd1);
    chk("single_data", {16'b0, b1_data}, 32'hBEEF);

    // Reset while a transaction sits in WAIT
    b0_cs = 1'b1; b0_addr = 13'h0040; lat = 50;
    repeat (3) cycle();
    chk("pre_rst_wait", {31'b0, sd_cs}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sd_cs", {31'b0, sd_cs}, 32'd0);
    chk("async_rst_ok", {29'b0, b0_ok, b1_ok, b2_ok}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("post_rst_data", {b0_data, b1_data | b2_data}, 32'd0);
    lat = 2; b0_cs = 1'b0; b1_cs = 1'b0;
    repeat (3) cycle();

    // Address moves while the request is in WAIT
    b0_cs = 1'b1; b0_addr = 13'h0010; lat = 4;
    s = glog_a.size();
    repeat (3) cycle();
    b0_addr = 13'h0011;
    repeat (14) cycle();
    chk("chg_count", glog_a.size(), s + 2);
    if (glog_a.size() >= s + 2) begin
      chk("chg_first", {18'b0, glog_a[s]}, 32'h0010);
      chk("chg_second", {18'b0, glog_a[s+1]}, 32'h0011);
    end
    chk("chg_ok", {31'b0, b0_ok}, 32'd1);
    b0_cs = 1'b0;
    repeat (3) cycle();

    // sd_ok already high going into ISSUE
    stale = 1'b1; lat = 3;
    cycle();
    b2_cs = 1'b1; b2_addr = 11'h007;
    repeat (10) cycle();
    stale = 1'b0;
    cycle();
    chk("stale_ok", {31'b0, b2_ok}, 32'd1);
    chk("stale_data", {16'b0, b2_data}, {16'b0, mem(14'h2807)});

    chk("wrap_cs", {31'b0, w_sd_cs}, 32'd1);
    chk("wrap_addr", {18'b0, w_sd_addr}, 32'h0001);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) b0_cs = ~b0_cs;
      if ($urandom_range(0, 3) == 0) b1_cs = ~b1_cs;
      if ($urandom_range(0, 3) == 0) b2_cs = ~b2_cs;
      if ($urandom_range(0, 5) == 0) b0_addr = 13'h1FF0 + 13'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) b1_addr = 11'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) b2_addr = 11'h7F0 + 11'($urandom_range(0, 3));
      if (!sd_cs) lat = $urandom_range(1, 4);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/jtcop_vram_arb.md
# jtcop_vram_arb

Arbiter that shares one SDRAM read slot between the three BAC06 tilemap VRAM readers (b0, b1, b2) of the video path. It sits between the video block's `b*ram_cs/addr/data/ok` ports and the SDRAM controller. It serialises their requests, maps each one into a common VRAM word space, and returns data with per-requester `ok` flags. It uses the same hold-until-match handshake as the other SDRAM slots.

## Interface
Parameters:
- `B0_BASE`, 14'h0000, word base of b0 region (8K words).
- `B1_BASE`, 14'h2000, word base of b1 region (2K words).
- `B2_BASE`, 14'h2800, word base of b2 region (2K words).

Ports:
- `clk`, in, 1, system clock; one clock domain.
- `rst`, in, 1, reset, asynchronous, active-high.
- `b0_cs`, in, 1, b0 request; held high while data is needed.
- `b0_addr`, in, 13, b0 word address.
- `b0_data`, out, 16, b0 read data.
- `b0_ok`, out, 1, b0 data valid for the current `b0_addr`.
- `b1_cs`/`b1_addr`[11]/`b1_data`[16]/`b1_ok`: same as b0, for b1.
- `b2_cs`/`b2_addr`[11]/`b2_data`[16]/`b2_ok`: same as b0, for b2.
- `sd_cs`, out, 1, SDRAM slot request.
- `sd_addr`, out, 14, SDRAM slot word address.
- `sd_data`, in, 16, SDRAM slot data.
- `sd_ok`, in, 1, SDRAM slot data valid.

## Operation
- Per requester `i` the block keeps: `tag_i` (last served address), `val_i` (tag valid), `dat_i` (16-bit data).
- `bi_ok = bi_cs & val_i & (bi_addr == tag_i)`. This is combinational on registered state.
- `bi_data = dat_i`.
- Pending is `pend_i = bi_cs & ~(val_i & bi_addr == tag_i) & ~(busy & grant == i)`.
- Address mapping:
  - b0 → `B0_BASE + b0_addr`.
  - b1 → `B1_BASE + {2'b0,b1_addr}`.
  - b2 → `B2_BASE + {2'b0,b2_addr}`.
  - Sums are truncated to 14 bits; wrap is silent.
- FSM states:
  - IDLE: `sd_cs=0`. If any `pend_i`, pick grant using round-robin starting after `last` (order b0→b1→b2→b0). Latch `req_addr` (the requester's address, raw) and the mapped `sd_addr`. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `sd_cs=1` for exactly one cycle. `sd_ok` is ignored in this state because it may be stale from a previous slot cycle. Go to WAIT.
  - WAIT: `sd_cs=1`. On `sd_ok`: `dat_g<=sd_data`, `tag_g<=req_addr`, `val_g<=1`, `last<=g`, go to GAP.
  - GAP: `sd_cs=0` for one cycle, which guarantees `sd_ok` drops between transactions. Go to IDLE.
- Address change mid-transaction: the transaction still completes and stores data for the old address. `ok` stays low because the address mismatches, so `pend` re-asserts and a new transaction is issued.
- `cs` dropping mid-transaction: the transaction completes and the result is cached. `val` is kept.
- Simultaneous pending requests: exactly one is granted per transaction. With all three pending, each is served once in three transactions.
- `sd_addr` is stable from IDLE exit until GAP exit.

## Timing
- Reset values:
  - `sd_cs=0`, `sd_addr=0`.
  - All `val_i=0`, `tag_i=0`, `dat_i=0`, therefore every `bi_ok=0` and `bi_data=0`.
  - `last=b2`, so b0 has first priority.
  - State is IDLE.
- Reset asserted mid-operation: all state clears immediately, `sd_cs` goes low asynchronously.
- Latency, with the request first visible on clock edge N while in IDLE:
  - `sd_cs` rises after edge N.
  - ISSUE occupies N+1; earliest WAIT is N+2.
  - If `sd_ok` is high at edge N+2, `bi_ok` rises after edge N+2.
  - Minimum 3 cycles from request to ok. Minimum transaction period is 4 cycles (IDLE, ISSUE, WAIT, GAP).
- `bi_ok` and `bi_data` stay constant while `bi_cs` and `bi_addr` are unchanged (hit). There is no SDRAM traffic on a hit.

## Configuration
- `JTCOP_VRAM_PRIO_EN` defined: fixed priority b0 > b1 > b2 in IDLE, and `last` is unused. b0 can starve b1 and b2; this suits the PCB's BG0 refresh-heavy timing.
- Not defined: round-robin as described in Operation.

## Test plan
- Reset: assert `rst` asynchronously mid-WAIT → `sd_cs=0` and all `ok=0` immediately; after release, state is IDLE and `b*_data=0`.
- Single read: `b1_cs=1`, `b1_addr=11'h005`, SDRAM model returns 16'hBEEF with `sd_ok` 2 cycles after `sd_cs` → `sd_addr=14'h2005`, `b1_ok=1`, `b1_data=16'hBEEF`; holding the address causes no further `sd_cs` pulse.
- Round-robin: all three `cs` high with new addresses → grant order b0, b1, b2, with `sd_cs` low for at least 1 cycle between grants. With the macro defined the order is b0, b1, b2 on first pass, and a new b0 address preempts b1.
- Address change during WAIT: `b0_addr` 13'h0010→13'h0011 → the first transaction stores tag 0x0010 and `b0_ok` stays 0; a second transaction with `sd_addr=14'h0011` follows, then `b0_ok=1`.
- Stale ok: `sd_ok` held high from the previous cycle when ISSUE starts → data is not captured in ISSUE; capture happens only in WAIT.
- Wrap: `B2_BASE=14'h3FFF`, `b2_addr=11'h002` → `sd_addr=14'h0001`.
